// File: rtl/ntt_schedule_controller.sv
// Schedule/sequencing engine for the multi-core NTT datapath.
// Generates per-stage read-side control (log_m, log_t, block index, even/odd bank addresses,
// ping-pong select) in forward or inverse stage order, and a PIPE_STAGES-delayed tag stream
// that tells the write-back side what each returning beat is.
module ntt_schedule_controller #(
  parameter int unsigned LOG_N          = 12,
  parameter int unsigned LOG_CORE_COUNT = 5,
  parameter int unsigned PIPE_STAGES    = 10,
  localparam int unsigned J             = LOG_N - 2 - LOG_CORE_COUNT,
  localparam int unsigned ADDR_W        = J,
  localparam int unsigned LW            = $clog2(LOG_N)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_inverse,
  input  logic              i_stall,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_rd_valid,
  output logic [LW-1:0]     o_log_m,
  output logic [LW-1:0]     o_log_t,
  output logic [ADDR_W-1:0] o_i,
  output logic [ADDR_W-1:0] o_even_read_address,
  output logic [ADDR_W-1:0] o_odd_read_address,
  output logic              o_read_select,
  output logic              o_wr_valid,
  output logic [ADDR_W-1:0] o_wr_even_address,
  output logic [ADDR_W-1:0] o_wr_odd_address,
  output logic [LW-1:0]     o_wr_log_m,
  output logic [LW-1:0]     o_wr_log_t,
  output logic              o_write_select,
  output logic              o_output_active
);

  localparam logic [LW-1:0]     LtTop  = LW'(LOG_N - 2);
  localparam logic [LW-1:0]     LtJ    = LW'(J);
  localparam logic [ADDR_W-1:0] CntMax = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_t;

  // One delay-line slot: everything the write-back side needs about a beat.
  typedef struct packed {
    logic              valid;
    logic              last;   // final beat of the whole transform
    logic              fin;    // beat belongs to the final stage
    logic              sel;
    logic [LW-1:0]     lm;
    logic [LW-1:0]     lt;
    logic [ADDR_W-1:0] ev;
    logic [ADDR_W-1:0] od;
  } tag_t;

  state_t            r_state;
  logic              r_inv;
  logic [ADDR_W-1:0] r_cnt;
  logic [LW-1:0]     r_log_t;
  logic              r_sel;
  tag_t              r_pipe [PIPE_STAGES];

  logic              w_active;
  logic              w_rd_valid;
  logic              w_last_stage;
  logic              w_phase_b;
  logic              w_done;
  logic [ADDR_W-1:0] w_mask;
  logic [ADDR_W-1:0] w_half;
  logic [ADDR_W-1:0] w_i;
  logic [ADDR_W-1:0] w_even;
  logic [ADDR_W-1:0] w_odd;
  tag_t              w_tag;

  assign w_active     = (r_state != StIdle);
  assign w_rd_valid   = (r_state == StRun) && !i_stall;
  assign w_last_stage = r_inv ? (r_log_t == LtTop) : (r_log_t == '0);
  assign w_phase_b    = (r_log_t != '0) && (r_log_t <= LtJ);
  assign w_done       = r_pipe[PIPE_STAGES-1].valid && r_pipe[PIPE_STAGES-1].last;

  // Address generation: phases A/C sweep linearly; phase B splits the counter into block
  // index (upper bits) and an in-block offset, with odd rotated by half a block.
  always_comb begin
    w_mask = (ADDR_W'(1) << r_log_t) - ADDR_W'(1);
    w_half = ADDR_W'(1) << (r_log_t - LW'(1));
    w_i    = '0;
    w_even = r_cnt;
    w_odd  = r_cnt;
    if (w_phase_b) begin
      w_i   = r_cnt >> r_log_t;
      w_odd = (r_cnt & ~w_mask) | ((r_cnt + w_half) & w_mask);
    end
  end

  // Control FSM and read-side counters; stalled RUN cycles leave everything untouched.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_inv   <= 1'b0;
      r_cnt   <= '0;
      r_log_t <= LtTop;
      r_sel   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_inv   <= i_inverse;
            r_cnt   <= '0;
            r_log_t <= i_inverse ? '0 : LtTop;
            r_sel   <= 1'b0;
            r_state <= StRun;
          end
        end
        StRun: begin
          if (!i_stall) begin
            if (r_cnt == CntMax) begin
              if (w_last_stage) begin
                r_state <= StDrain;
              end else begin
                r_cnt   <= '0;
                r_sel   <= ~r_sel;
                r_log_t <= r_inv ? (r_log_t + LW'(1)) : (r_log_t - LW'(1));
              end
            end else begin
              r_cnt <= r_cnt + ADDR_W'(1);
            end
          end
        end
        StDrain: begin
          if (w_done) begin
            r_state <= StIdle;
            r_inv   <= 1'b0;
            r_cnt   <= '0;
            r_log_t <= LtTop;
            r_sel   <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    w_tag       = '0;
    w_tag.valid = w_rd_valid;
    w_tag.last  = w_rd_valid && w_last_stage && (r_cnt == CntMax);
    w_tag.fin   = w_last_stage;
    w_tag.sel   = r_sel;
    w_tag.lm    = o_log_m;
    w_tag.lt    = r_log_t;
    w_tag.ev    = o_even_read_address;
    w_tag.od    = o_odd_read_address;
  end

  // Write-back tag delay line; bubbles travel through it like real beats.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < PIPE_STAGES; k++) r_pipe[k] <= '0;
    end else begin
      r_pipe[0] <= w_tag;
      for (int k = 1; k < PIPE_STAGES; k++) r_pipe[k] <= r_pipe[k-1];
    end
  end

  assign o_busy              = w_active;
  assign o_rd_valid          = w_rd_valid;
  assign o_log_t             = r_log_t;
  assign o_log_m             = LtTop - r_log_t;
  assign o_i                 = w_active ? w_i : '0;
  assign o_even_read_address = w_active ? w_even : '0;
  assign o_odd_read_address  = w_active ? w_odd : '0;
  assign o_read_select       = r_sel;

  assign o_wr_valid        = r_pipe[PIPE_STAGES-1].valid;
  assign o_wr_even_address = r_pipe[PIPE_STAGES-1].ev;
  assign o_wr_odd_address  = r_pipe[PIPE_STAGES-1].od;
  assign o_wr_log_m        = r_pipe[PIPE_STAGES-1].lm;
  assign o_wr_log_t        = r_pipe[PIPE_STAGES-1].lt;
  assign o_write_select    = r_pipe[PIPE_STAGES-1].sel;
  assign o_output_active   = r_pipe[PIPE_STAGES-1].valid && r_pipe[PIPE_STAGES-1].fin;
  assign o_done            = w_done;

endmodule

// File: tb/tb_ntt_schedule_controller.sv
// Scoreboard bench for ntt_schedule_controller: stimulus pushes the expected read and
// write-back beats (with their cycle numbers) into queues; a negedge monitor pops and compares.
module tb_ntt_schedule_controller;

  localparam int LOG_N = 12;
  localparam int LCC   = 5;
  localparam int P     = 10;
  localparam int J     = 5;
  localparam int NB    = 1 << J;
  localparam int LW    = 4;
  localparam int AW    = 5;

  logic clk = 1'b0;
  logic rst, start, inverse, stall;
  logic busy, done, rd_valid, read_select, wr_valid, write_select, output_active;
  logic [LW-1:0] log_m, log_t, wr_log_m, wr_log_t;
  logic [AW-1:0] idx, even_a, odd_a, wr_even, wr_odd;

  ntt_schedule_controller #(.LOG_N(LOG_N), .LOG_CORE_COUNT(LCC), .PIPE_STAGES(P)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_inverse(inverse), .i_stall(stall),
    .o_busy(busy), .o_done(done), .o_rd_valid(rd_valid), .o_log_m(log_m), .o_log_t(log_t),
    .o_i(idx), .o_even_read_address(even_a), .o_odd_read_address(odd_a),
    .o_read_select(read_select), .o_wr_valid(wr_valid), .o_wr_even_address(wr_even),
    .o_wr_odd_address(wr_odd), .o_wr_log_m(wr_log_m), .o_wr_log_t(wr_log_t),
    .o_write_select(write_select), .o_output_active(output_active)
  );

  // Small configuration: LOG_N=8, LOG_CORE_COUNT=2, PIPE_STAGES=3 -> J=4, LW=3.
  logic s_start = 1'b0, s_inverse = 1'b0, s_stall = 1'b0;
  logic s_busy, s_done, s_rd_valid, s_rsel, s_wr_valid, s_wsel, s_oact;
  logic [2:0] s_lm, s_lt, s_wlm, s_wlt;
  logic [3:0] s_i, s_ev, s_od, s_wev, s_wod;

  ntt_schedule_controller #(.LOG_N(8), .LOG_CORE_COUNT(2), .PIPE_STAGES(3)) dut_small (
    .i_clk(clk), .i_rst(rst), .i_start(s_start), .i_inverse(s_inverse), .i_stall(s_stall),
    .o_busy(s_busy), .o_done(s_done), .o_rd_valid(s_rd_valid), .o_log_m(s_lm), .o_log_t(s_lt),
    .o_i(s_i), .o_even_read_address(s_ev), .o_odd_read_address(s_od),
    .o_read_select(s_rsel), .o_wr_valid(s_wr_valid), .o_wr_even_address(s_wev),
    .o_wr_odd_address(s_wod), .o_wr_log_m(s_wlm), .o_wr_log_t(s_wlt),
    .o_write_select(s_wsel), .o_output_active(s_oact)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pack(input logic [31:0] lt, input logic [31:0] lm,
                                       input logic [31:0] ii, input logic [31:0] ev,
                                       input logic [31:0] od, input logic [31:0] sel);
    return (lt << 20) | (lm << 16) | (ii << 11) | (ev << 6) | (od << 1) | sel;
  endfunction

  typedef struct {
    int          cyc;
    logic [31:0] fields;
    bit          fin;
    bit          last;
  } exp_t;

  exp_t rd_q[$];
  exp_t wr_q[$];

  // Stall driver: window in absolute cycle numbers.
  int stall_from = 0;
  int stall_len  = 0;
  always @(posedge clk) begin
    #1;
    stall = (stall_len > 0) && (cyc >= stall_from) && (cyc < stall_from + stall_len);
  end

  // Reference schedule built straight from the stage/phase definitions.
  task automatic push_model(input int t0, input bit inv, input int sfrom, input int slen);
    int t = t0;
    exp_t e;
    for (int s = 0; s <= LOG_N - 2; s++) begin
      int lt = inv ? s : (LOG_N - 2 - s);
      int lm = LOG_N - 2 - lt;
      for (int c = 0; c < NB; c++) begin
        int ii, ev, od;
        if (lt > J || lt == 0) begin
          ii = 0; ev = c; od = c;
        end else begin
          int size = 1 << lt;
          int k = c % size;
          ii = c / size;
          ev = ii * size + k;
          od = ii * size + ((k + size / 2) % size);
        end
        while (slen > 0 && t >= sfrom && t < sfrom + slen) t++;
        e.fin  = (s == LOG_N - 2);
        e.last = e.fin && (c == NB - 1);
        e.cyc = t;
        e.fields = pack(lt, lm, ii, ev, od, s % 2);
        rd_q.push_back(e);
        e.cyc = t + P;
        e.fields = pack(lt, lm, 0, ev, od, s % 2);
        wr_q.push_back(e);
        t++;
      end
    end
  endtask

  bit   sb_off = 1'b0;
  bit   busy_low_pending = 1'b0;
  exp_t m;

  // Monitor: every presented read or write-back beat must match the head of its queue.
  always @(negedge clk) begin
    if (!sb_off && !rst) begin
      if (busy_low_pending) begin
        check("busy_after_done", busy, 0);
        busy_low_pending = 1'b0;
      end
      if (rd_valid) begin
        if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
        else begin
          m = rd_q.pop_front();
          check("rd_cycle", cyc, m.cyc);
          check("rd_fields", pack(log_t, log_m, idx, even_a, odd_a, read_select), m.fields);
        end
      end
      if (wr_valid) begin
        if (wr_q.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          m = wr_q.pop_front();
          check("wr_cycle", cyc, m.cyc);
          check("wr_fields", pack(wr_log_t, wr_log_m, 0, wr_even, wr_odd, write_select),
                m.fields);
          check("output_active", output_active, m.fin);
          check("done", done, m.last);
          if (m.last) begin
            check("busy_at_done", busy, 1);
            busy_low_pending = 1'b1;
          end
        end
      end else if (done) begin
        check("done_without_wr", 1, 0);
      end
    end
  end

  task automatic check_reset_values(input string tag);
    @(negedge clk);
    check({tag, "_ctrl"}, {busy, done, rd_valid, wr_valid, output_active, read_select,
                           write_select}, 0);
    check({tag, "_log_t"}, log_t, LOG_N - 2);
    check({tag, "_addr"}, {log_m, idx, even_a, odd_a, wr_even, wr_odd, wr_log_m, wr_log_t}, 0);
  endtask

  task automatic do_start(input bit inv, input bit model, input int soff, input int slen);
    int t0;
    @(posedge clk);
    #1;
    start = 1'b1;
    inverse = inv;
    t0 = cyc;
    stall_from = t0 + 1 + soff;
    stall_len = slen;
    if (model) push_model(t0 + 1, inv, stall_from, slen);
    @(posedge clk);
    #1;
    start = 1'b0;
    inverse = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    for (n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (rd_q.size() == 0 && wr_q.size() == 0) break;
    end
    check({tag, "_drained"}, rd_q.size() + wr_q.size(), 0);
    rd_q.delete();
    wr_q.delete();
    repeat (2) @(negedge clk);
    check({tag, "_idle"}, busy, 0);
    stall_len = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_rd, s_wr, s_done_at, s_act, seen_done;
    rst = 1'b1; start = 1'b0; inverse = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_values("reset");

    // Plain forward transform.
    do_start(1'b0, 1'b1, 0, 0);
    wait_done("forward");

    // Inverse stage order.
    do_start(1'b1, 1'b1, 0, 0);
    wait_done("inverse");

    // Forward with a 5-cycle stall mid-stage, plus an ignored start while busy.
    do_start(1'b0, 1'b1, 100, 5);
    repeat (40) @(posedge clk);
    #1 start = 1'b1; inverse = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; inverse = 1'b0;
    wait_done("stall");

    // Abort by reset partway through; nothing may come out afterwards.
    sb_off = 1'b1;
    do_start(1'b0, 1'b0, 0, 0);
    repeat (98) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_reset_values("abort");
    sb_off = 1'b0;
    seen_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    check("abort_no_done", seen_done, 0);

    // Fresh start after the abort.
    do_start(1'b0, 1'b1, 0, 0);
    wait_done("restart");

    // Small configuration: 7 stages x 16 beats.
    @(posedge clk);
    #1 s_start = 1'b1;
    @(posedge clk);
    #1 s_start = 1'b0;
    s_rd = 0; s_wr = 0; s_done_at = 0; s_act = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (s_rd_valid) s_rd++;
      if (s_wr_valid) s_wr++;
      if (s_oact) s_act++;
      if (s_done) begin
        s_done_at = s_wr;
        break;
      end
    end
    check("small_rd_beats", s_rd, 112);
    check("small_done_beat", s_done_at, 112);
    check("small_output_active", s_act, 16);
    @(negedge clk);
    check("small_idle", s_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
